// File: rtl/ps2_keymatrix_if.sv
// PS/2 lines, CPU row select and matrix result shared by the host side and the keyboard front-end.
interface ps2_keymatrix_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] a_hi;
  logic [4:0] kd;
  logic       key_rst_n;

  modport master (output ps2_clk, ps2_dat, a_hi, input kd, key_rst_n);
  modport slave  (input ps2_clk, ps2_dat, a_hi, output kd, key_rst_n);
endinterface

// File: rtl/ps2_keymatrix.sv
// PS/2 set-2 keyboard front-end synthesising the ZX Spectrum 8x5 key matrix.
// Optional Ctrl+Alt+Del reset request enabled by defining PS2_RESET_KEY_EN.
module ps2_keymatrix #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 14000
) (
  input  logic           rst_n,
  input  logic           clk14,
  ps2_keymatrix_if.slave bus
);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  typedef logic [7:0][4:0] kmat_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_f;
  logic [FW-1:0] flt_cnt;
  logic          edge_ev, fall;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  rx_state_t state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic       par, par_nx;
  logic       byte_ok, byte_rdy;
  logic [7:0] byte_q;
  logic       ext, rel;
  kmat_t      matrix, mask;
  logic [4:0] kd_v;

  // A level change is taken only once the synchronised clock has differed for FILTER_LEN cycles.
  assign edge_ev = (clk_sync[1] != clk_f) && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall    = edge_ev && clk_f;
  assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_f    <= 1'b1;
      flt_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      clk_sync <= {clk_sync[0], bus.ps2_clk};
      dat_sync <= {dat_sync[0], bus.ps2_dat};
      if (clk_sync[1] == clk_f) flt_cnt <= '0;
      else if (edge_ev) begin
        clk_f   <= clk_sync[1];
        flt_cnt <= '0;
      end else flt_cnt <= flt_cnt + FW'(1);
      if (edge_ev) to_cnt <= '0;
      else if (!timeout) to_cnt <= to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      byte_rdy <= 1'b0;
      byte_q   <= '0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_cnt_nx;
      shreg    <= shreg_nx;
      par      <= par_nx;
      byte_rdy <= byte_ok;
      if (byte_ok) byte_q <= shreg;
    end
  end

  // A real edge takes priority over the saturated timeout so a start bit after long idle is kept.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_nx     = par;
    byte_ok    = 1'b0;
    if (fall) begin
      case (state)
        IDLE: if (!dat_sync[1]) begin
          state_nx   = DATA;
          bit_cnt_nx = '0;
        end
        DATA: begin
          shreg_nx   = {dat_sync[1], shreg[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = PARITY;
        end
        PARITY: begin
          par_nx   = dat_sync[1];
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          byte_ok  = dat_sync[1] && (^{shreg, par});
        end
        default: state_nx = IDLE;
      endcase
    end else if (timeout) begin
      state_nx   = IDLE;
      bit_cnt_nx = '0;
    end
  end

  function automatic kmat_t key_mask(input logic e, input logic [7:0] c);
    kmat_t m;
    m = '0;
    if (!e) begin
      case (c)
        8'h12, 8'h59: m[0][0] = 1'b1;
        8'h1A: m[0][1] = 1'b1;  8'h22: m[0][2] = 1'b1;  8'h21: m[0][3] = 1'b1;  8'h2A: m[0][4] = 1'b1;
        8'h1C: m[1][0] = 1'b1;  8'h1B: m[1][1] = 1'b1;  8'h23: m[1][2] = 1'b1;  8'h2B: m[1][3] = 1'b1;
        8'h34: m[1][4] = 1'b1;  8'h15: m[2][0] = 1'b1;  8'h1D: m[2][1] = 1'b1;  8'h24: m[2][2] = 1'b1;
        8'h2D: m[2][3] = 1'b1;  8'h2C: m[2][4] = 1'b1;  8'h16: m[3][0] = 1'b1;  8'h1E: m[3][1] = 1'b1;
        8'h26: m[3][2] = 1'b1;  8'h25: m[3][3] = 1'b1;  8'h2E: m[3][4] = 1'b1;  8'h45: m[4][0] = 1'b1;
        8'h46: m[4][1] = 1'b1;  8'h3E: m[4][2] = 1'b1;  8'h3D: m[4][3] = 1'b1;  8'h36: m[4][4] = 1'b1;
        8'h4D: m[5][0] = 1'b1;  8'h44: m[5][1] = 1'b1;  8'h43: m[5][2] = 1'b1;  8'h3C: m[5][3] = 1'b1;
        8'h35: m[5][4] = 1'b1;  8'h5A: m[6][0] = 1'b1;  8'h4B: m[6][1] = 1'b1;  8'h42: m[6][2] = 1'b1;
        8'h3B: m[6][3] = 1'b1;  8'h33: m[6][4] = 1'b1;  8'h29: m[7][0] = 1'b1;  8'h14: m[7][1] = 1'b1;
        8'h3A: m[7][2] = 1'b1;  8'h31: m[7][3] = 1'b1;  8'h32: m[7][4] = 1'b1;
        8'h66: begin m[0][0] = 1'b1; m[4][0] = 1'b1; end
        8'h76: begin m[0][0] = 1'b1; m[7][0] = 1'b1; end
        default: ;
      endcase
    end else begin
      case (c)
        8'h14: m[7][1] = 1'b1;
        8'h6B: begin m[0][0] = 1'b1; m[3][4] = 1'b1; end
        8'h72: begin m[0][0] = 1'b1; m[4][4] = 1'b1; end
        8'h75: begin m[0][0] = 1'b1; m[4][3] = 1'b1; end
        8'h74: begin m[0][0] = 1'b1; m[4][2] = 1'b1; end
        default: ;
      endcase
    end
    return m;
  endfunction

  assign mask = key_mask(ext, byte_q);

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      matrix <= '0;
      ext    <= 1'b0;
      rel    <= 1'b0;
    end else if (byte_rdy) begin
      case (byte_q)
        8'hE0: ext <= 1'b1;
        8'hF0: rel <= 1'b1;
        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
        default: begin
          matrix <= rel ? (matrix & ~mask) : (matrix | mask);
          ext    <= 1'b0;
          rel    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    kd_v = '1;
    for (int unsigned r = 0; r < 8; r++)
      if (!bus.a_hi[r[2:0]]) kd_v = kd_v & ~matrix[r[2:0]];
  end
  assign bus.kd = kd_v;

`ifdef PS2_RESET_KEY_EN
  logic ctrl_h, alt_h, del_h, krst_n;

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_h <= 1'b0;
      alt_h  <= 1'b0;
      del_h  <= 1'b0;
      krst_n <= 1'b1;
    end else begin
      krst_n <= ~(ctrl_h & alt_h & del_h);
      if (byte_rdy) begin
        case (byte_q)
          8'h14: ctrl_h <= ~rel;
          8'h11: alt_h  <= ~rel;
          8'h71: if (ext) del_h <= ~rel;
          default: ;
        endcase
      end
    end
  end
  assign bus.key_rst_n = krst_n;
`else
  assign bus.key_rst_n = 1'b1;
`endif
endmodule

// File: tb/tb_ps2_keymatrix.sv
// Bench for ps2_keymatrix: directed vector table, corner sequences, and random key traffic
// compared against a scancode/layout reference model.
`timescale 1ns/1ps
module tb_ps2_keymatrix;
  localparam int HALF = 16;
  localparam int SLOW_HALF = 595;

  logic clk14 = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ps2_keymatrix_if bus();
  ps2_keymatrix #(.FILTER_LEN(8), .TIMEOUT_CYCLES(14000)) dut (.rst_n(rst_n), .clk14(clk14), .bus(bus));

  always #35 clk14 = ~clk14;

  string layout [8][5] = '{
    '{"CS", "Z", "X", "C", "V"}, '{"A", "S", "D", "F", "G"}, '{"Q", "W", "E", "R", "T"},
    '{"1", "2", "3", "4", "5"},  '{"0", "9", "8", "7", "6"}, '{"P", "O", "I", "U", "Y"},
    '{"ENT", "L", "K", "J", "H"}, '{"SP", "SS", "M", "N", "B"}};

  typedef struct { bit ext; logic [7:0] code; string k1; string k2; } map_t;
  typedef struct { bit ext; logic [7:0] code; } key_t;
  typedef struct { int n; logic [7:0] b0, b1, b2; bit bad; logic [7:0] a; logic [4:0] kd; } vec_t;

  map_t keymap[$];
  key_t pool[$];
  vec_t vt[$];
  bit   mdl [8][5];
  bit   m_ext, m_rel, m_ctrl, m_alt, m_del;

  task automatic add(input bit e, input logic [7:0] c, input string k1, input string k2 = "");
    map_t m;
    key_t k;
    m.ext = e; m.code = c; m.k1 = k1; m.k2 = k2;
    keymap.push_back(m);
    k.ext = e; k.code = c;
    pool.push_back(k);
  endtask

  task automatic build_map();
    key_t k;
    add(0, 'h12, "CS"); add(0, 'h59, "CS"); add(0, 'h1A, "Z"); add(0, 'h22, "X"); add(0, 'h21, "C");
    add(0, 'h2A, "V");  add(0, 'h1C, "A");  add(0, 'h1B, "S"); add(0, 'h23, "D"); add(0, 'h2B, "F");
    add(0, 'h34, "G");  add(0, 'h15, "Q");  add(0, 'h1D, "W"); add(0, 'h24, "E"); add(0, 'h2D, "R");
    add(0, 'h2C, "T");  add(0, 'h16, "1");  add(0, 'h1E, "2"); add(0, 'h26, "3"); add(0, 'h25, "4");
    add(0, 'h2E, "5");  add(0, 'h45, "0");  add(0, 'h46, "9"); add(0, 'h3E, "8"); add(0, 'h3D, "7");
    add(0, 'h36, "6");  add(0, 'h4D, "P");  add(0, 'h44, "O"); add(0, 'h43, "I"); add(0, 'h3C, "U");
    add(0, 'h35, "Y");  add(0, 'h5A, "ENT"); add(0, 'h4B, "L"); add(0, 'h42, "K"); add(0, 'h3B, "J");
    add(0, 'h33, "H");  add(0, 'h29, "SP"); add(0, 'h14, "SS"); add(1, 'h14, "SS"); add(0, 'h3A, "M");
    add(0, 'h31, "N");  add(0, 'h32, "B");  add(0, 'h66, "CS", "0"); add(0, 'h76, "CS", "SP");
    add(1, 'h6B, "CS", "5"); add(1, 'h72, "CS", "6"); add(1, 'h75, "CS", "7"); add(1, 'h74, "CS", "8");
    // keys outside the matrix: Alt, Del, keypad 8, keypad Enter, F1
    k.ext = 0; k.code = 'h11; pool.push_back(k);
    k.ext = 1; k.code = 'h11; pool.push_back(k);
    k.ext = 1; k.code = 'h71; pool.push_back(k);
    k.ext = 0; k.code = 'h75; pool.push_back(k);
    k.ext = 1; k.code = 'h5A; pool.push_back(k);
    k.ext = 0; k.code = 'h05; pool.push_back(k);
  endtask

  task automatic model_reset();
    foreach (mdl[r, c]) mdl[r][c] = 1'b0;
    m_ext = 0; m_rel = 0; m_ctrl = 0; m_alt = 0; m_del = 0;
  endtask

  task automatic set_key(input string k, input bit v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (layout[r][c] == k) mdl[r][c] = v;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) return;
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0) begin m_rel = 1; return; end
    foreach (keymap[i])
      if (keymap[i].ext == m_ext && keymap[i].code == b) begin
        set_key(keymap[i].k1, !m_rel);
        if (keymap[i].k2 != "") set_key(keymap[i].k2, !m_rel);
      end
    if (b == 8'h14) m_ctrl = !m_rel;
    if (b == 8'h11) m_alt = !m_rel;
    if (b == 8'h71 && m_ext) m_del = !m_rel;
    m_ext = 0; m_rel = 0;
  endtask

  function automatic logic [4:0] exp_kd(input logic [7:0] a);
    logic [4:0] k;
    k = 5'b11111;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!a[r] && mdl[r][c]) k[c] = 1'b0;
    return k;
  endfunction

  function automatic logic exp_krst();
`ifdef PS2_RESET_KEY_EN
    return !(m_ctrl && m_alt && m_del);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_kd(input string name, input logic [7:0] a, input logic [4:0] exp);
    @(negedge clk14);
    bus.a_hi = a;
    #2;
    check(name, {3'b000, bus.kd}, {3'b000, exp});
  endtask

  task automatic check_krst(input string name, input logic exp);
    @(negedge clk14);
    check(name, {7'd0, bus.key_rst_n}, {7'd0, exp});
  endtask

  // Drives the first n bits of a frame (start, 8 data LSB first, odd parity, stop).
  task automatic send_bits(input logic [7:0] b, input bit bad, input int n, input int half);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      bus.ps2_dat = f[i];
      repeat (half) @(posedge clk14);
      bus.ps2_clk = 1'b0;
      repeat (half) @(posedge clk14);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad = 0, input int half = HALF);
    send_bits(b, bad, 11, half);
    bus.ps2_dat = 1'b1;
    repeat (24) @(posedge clk14);
    if (!bad) model_byte(b);
  endtask

  task automatic v(input int n, input logic [7:0] b0, b1, b2, input bit bad,
                   input logic [7:0] a, input logic [4:0] kd);
    vec_t x;
    x.n = n; x.b0 = b0; x.b1 = b1; x.b2 = b2; x.bad = bad; x.a = a; x.kd = kd;
    vt.push_back(x);
  endtask

  task automatic press_release(input key_t k, input bit rel);
    if (k.ext) send_frame(8'hE0);
    if (rel) send_frame(8'hF0);
    send_frame(k.code);
  endtask

  initial begin
    #30_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    key_t k;
    logic [7:0] a;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    bus.a_hi    = 8'hFF;
    build_map();
    model_reset();

    v(2, 'hF0, 'h1C, 0, 0, 'hFD, 5'b11111);
    v(1, 'h1C, 0, 0, 1, 'hFD, 5'b11111);
    v(1, 'h66, 0, 0, 0, 'hFE, 5'b11110);
    v(0, 0, 0, 0, 0, 'hEF, 5'b11110);
    v(0, 0, 0, 0, 0, 'h00, 5'b11110);
    v(0, 0, 0, 0, 0, 'hFF, 5'b11111);
    v(2, 'hF0, 'h66, 0, 0, 'h00, 5'b11111);
    v(2, 'hE0, 'h75, 0, 0, 'hFE, 5'b11110);
    v(0, 0, 0, 0, 0, 'hEF, 5'b10111);
    v(2, 'hF0, 'h75, 0, 0, 'hEF, 5'b10111);
    v(3, 'hE0, 'hF0, 'h75, 0, 'h00, 5'b11111);
    v(2, 'hAA, 'h15, 0, 0, 'hFB, 5'b11110);
    v(3, 'hE0, 'hFA, 'h14, 0, 'h7F, 5'b11101);
    v(3, 'hE0, 'hF0, 'h14, 0, 'h7F, 5'b11111);
    v(2, 'hF0, 'h15, 0, 0, 'hFB, 5'b11111);
    v(1, 'h12, 0, 0, 0, 'hFE, 5'b11110);
    v(1, 'h76, 0, 0, 0, 'h7F, 5'b11110);
    v(2, 'hF0, 'h76, 0, 0, 'hFE, 5'b11111);
    v(0, 0, 0, 0, 0, 'h7F, 5'b11111);
    v(2, 'hF0, 'h12, 0, 0, 'h00, 5'b11111);
    v(1, 'h59, 0, 0, 0, 'hFE, 5'b11110);
    v(2, 'hF0, 'h59, 0, 0, 'hFE, 5'b11111);
    v(2, 'hE0, 'h6B, 0, 0, 'h00, 5'b01110);
    v(3, 'hE0, 'hF0, 'h6B, 0, 'h00, 5'b11111);

    repeat (5) @(posedge clk14);
    check_kd("reset_kd", 8'h00, 5'b11111);
    check_krst("reset_key_rst_n", 1'b1);
    rst_n = 1'b1;
    repeat (5) @(posedge clk14);

    send_frame(8'h1C, 0, SLOW_HALF);
    check_kd("slow_A_make", 8'hFD, 5'b11110);

    foreach (vt[i]) begin
      if (vt[i].n > 0) send_frame(vt[i].b0, vt[i].n == 1 && vt[i].bad);
      if (vt[i].n > 1) send_frame(vt[i].b1, vt[i].n == 2 && vt[i].bad);
      if (vt[i].n > 2) send_frame(vt[i].b2, vt[i].n == 3 && vt[i].bad);
      check_kd($sformatf("vec%0d", i), vt[i].a, vt[i].kd);
    end

    // partial frame, long idle, then a sub-filter glitch with data low
    send_bits(8'h1C, 0, 5, HALF);
    repeat (20000) @(posedge clk14);
    bus.ps2_dat = 1'b0;
    bus.ps2_clk = 1'b0;
    repeat (4) @(posedge clk14);
    bus.ps2_clk = 1'b1;
    repeat (30) @(posedge clk14);
    send_frame(8'h16);
    check_kd("timeout_then_1", 8'hF7, 5'b11110);
    send_frame(8'hF0); send_frame(8'h16);
    check_kd("timeout_release_1", 8'hF7, 5'b11111);

    send_frame(8'h14);
    check_krst("krst_ctrl_only", exp_krst());
    send_frame(8'h11);
    check_krst("krst_ctrl_alt", exp_krst());
    send_frame(8'hE0); send_frame(8'h71);
`ifdef PS2_RESET_KEY_EN
    check_krst("krst_all_held", 1'b0);
`else
    check_krst("krst_disabled", 1'b1);
`endif
    send_frame(8'hF0); send_frame(8'h11);
    check_krst("krst_alt_released", 1'b1);
    check_kd("ctrl_still_ss", 8'h7F, 5'b11101);
    send_frame(8'hF0); send_frame(8'h14);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h71);

    send_frame(8'h1C);
    send_bits(8'h2B, 0, 5, HALF);
    rst_n = 1'b0;
    model_reset();
    check_kd("reset_mid_frame", 8'h00, 5'b11111);
    repeat (3) @(posedge clk14);
    rst_n = 1'b1;
    repeat (5) @(posedge clk14);
    send_frame(8'h1C);
    check_kd("after_reset_frame", 8'hFD, 5'b11110);

    for (int it = 0; it < 24; it++) begin
      k = pool[$urandom_range(0, pool.size() - 1)];
      press_release(k, $urandom_range(0, 1) == 1);
      a = 8'($urandom);
      check_kd($sformatf("rnd%0d_any", it), a, exp_kd(a));
      a = ~(8'd1 << $urandom_range(0, 7));
      check_kd($sformatf("rnd%0d_row", it), a, exp_kd(a));
      check_krst($sformatf("rnd%0d_krst", it), exp_krst());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
